// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for the fixed banded system (diag 20, bands -13/+6/-1).
// Loads N b samples, sweeps in place until tolerance or MAX_ITER, then streams x out.
module gsim_band_solver #(
    parameter int N        = 16,
    parameter int B_W      = 16,
    parameter int X_W      = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 255,
    parameter int IW       = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_en,
    input  logic [B_W-1:0] b_in,
    input  logic [X_W-1:0] tol,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] x_out,
    output logic           x_last,
    output logic [IW-1:0]  iter_cnt,
    output logic           timeout
);
    localparam int KW = $clog2(N);
    localparam int KE = KW + 2;
    localparam int SW = X_W + 6;
    localparam int PW = SW + 13;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]            state;
    logic [KW-1:0]         k, r, j;
    logic signed [X_W-1:0] x [N];
    logic signed [B_W-1:0] b [N];
    logic [X_W-1:0]        tol_q;
    logic [X_W:0]          maxd;

    logic signed [X_W-1:0] xm1, xm2, xm3, xp1, xp2, xp3, xc, x_new;
    logic signed [SW-1:0]  s_sum;
    logic signed [PW-1:0]  q;
    logic signed [X_W:0]   diff;
    logic [X_W:0]          d, maxd_cur;
    logic [KE-1:0]         re;
    logic                  conv, cap;
    logic [IW-1:0]         iter_next;

    // Neighbour fetch: indices outside 0..N-1 read as zero.
    always_comb begin
        xm1 = '0; xm2 = '0; xm3 = '0;
        xp1 = '0; xp2 = '0; xp3 = '0;
        re  = {2'b00, r};
        xc  = x[r];
        if (re >= KE'(1)) xm1 = x[r - KW'(1)];
        if (re >= KE'(2)) xm2 = x[r - KW'(2)];
        if (re >= KE'(3)) xm3 = x[r - KW'(3)];
        if (re + KE'(1) < KE'(N)) xp1 = x[r + KW'(1)];
        if (re + KE'(2) < KE'(N)) xp2 = x[r + KW'(2)];
        if (re + KE'(3) < KE'(N)) xp3 = x[r + KW'(3)];
    end

    always_comb begin
        s_sum = (SW'(b[r]) <<< FRAC)
              + SW'(13) * (SW'(xm1) + SW'(xp1))
              - SW'(6)  * (SW'(xm2) + SW'(xp2))
              + SW'(xm3) + SW'(xp3);
        q = (PW'(s_sum) * PW'(3277)) >>> 16;
        if ((&q[PW-1:X_W-1]) || !(|q[PW-1:X_W-1]))
            x_new = q[X_W-1:0];
        else
            x_new = q[PW-1] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
        diff      = {x_new[X_W-1], x_new} - {xc[X_W-1], xc};
        d         = diff[X_W] ? -diff : diff;
        maxd_cur  = (r == '0 || d > maxd) ? d : maxd;
        conv      = (maxd_cur <= {1'b0, tol_q});
        iter_next = iter_cnt + IW'(1);
        cap       = (iter_next == IW'(MAX_ITER));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            k        <= '0;
            r        <= '0;
            j        <= '0;
            tol_q    <= '0;
            maxd     <= '0;
            iter_cnt <= '0;
            timeout  <= 1'b0;
            x        <= '{default: '0};
            b        <= '{default: '0};
        end else begin
            case (state)
                IDLE: if (in_en) begin
                    b[k]     <= b_in;
                    tol_q    <= tol;
                    x        <= '{default: '0};
                    iter_cnt <= '0;
                    timeout  <= 1'b0;
                    k        <= k + KW'(1);
                    state    <= LOAD;
                end
                LOAD: if (in_en) begin
                    b[k] <= b_in;
                    if (k == KW'(N - 1)) begin
                        k     <= '0;
                        r     <= '0;
                        state <= ITER;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ITER: begin
                    x[r] <= x_new;
                    maxd <= maxd_cur;
                    if (r == KW'(N - 1)) begin
                        r        <= '0;
                        iter_cnt <= iter_next;
                        if (conv) begin
                            state <= OUT;
                        end else if (cap) begin
                            timeout <= 1'b1;
                            state   <= OUT;
                        end
                    end else begin
                        r <= r + KW'(1);
                    end
                end
                OUT: if (out_ready) begin
                    if (j == KW'(N - 1)) begin
                        j     <= '0;
                        state <= IDLE;
                    end else begin
                        j <= j + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign x_out     = out_valid ? x[j] : '0;
    assign x_last    = out_valid && (j == KW'(N - 1));

endmodule

// File: tb/tb_gsim_band_solver.sv
// Directed bench for gsim_band_solver: two instances (MAX_ITER 255 and 4) share
// stimulus; a behavioural Gauss-Seidel model fills per-instance scoreboards.
module tb_gsim_band_solver;
    localparam int N = 16, B_W = 16, X_W = 32, FRAC = 16, IW = 8;

    logic           clk = 1'b0;
    logic           reset_n, in_en, out_ready;
    logic [B_W-1:0] b_in;
    logic [X_W-1:0] tol;
    logic           busy_a, ov_a, xl_a, to_a, busy_t, ov_t, xl_t, to_t;
    logic [X_W-1:0] xo_a, xo_t;
    logic [IW-1:0]  it_a, it_t;

    gsim_band_solver #(.N(N), .B_W(B_W), .X_W(X_W), .FRAC(FRAC), .MAX_ITER(255), .IW(IW)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_en(in_en), .b_in(b_in), .tol(tol),
        .busy(busy_a), .out_valid(ov_a), .out_ready(out_ready), .x_out(xo_a),
        .x_last(xl_a), .iter_cnt(it_a), .timeout(to_a));

    gsim_band_solver #(.N(N), .B_W(B_W), .X_W(X_W), .FRAC(FRAC), .MAX_ITER(4), .IW(IW)) dut_t (
        .clk(clk), .reset_n(reset_n), .in_en(in_en), .b_in(b_in), .tol(tol),
        .busy(busy_t), .out_valid(ov_t), .out_ready(out_ready), .x_out(xo_t),
        .x_last(xl_t), .iter_cnt(it_t), .timeout(to_t));

    always #5 clk = ~clk;

    typedef struct {
        logic [X_W-1:0] x;
        logic           last;
    } exp_t;

    exp_t   qa[$], qt[$];
    longint bvec[N];
    longint mx[N];
    int     n_cmp = 0, n_bad = 0;
    int     cyc = 0, load_start = 0;
    int     exp_it_a, exp_it_t, rise_a, rise_t, xfer_a, xfer_t;
    bit     exp_to_a, exp_to_t, pv_a, pv_t;
    logic [X_W-1:0] first_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: x_out must equal the queue head whenever valid (covers stalls).
    always @(negedge clk) begin
        if (!reset_n) begin
            pv_a = 1'b0;
            pv_t = 1'b0;
        end else begin
            if (ov_a) begin
                if (qa.size() == 0) chk("a_extra_out", 64'(qa.size()), 64'd1);
                else begin
                    chk("a_x_out", xo_a, qa[0].x);
                    chk("a_x_last", xl_a, qa[0].last);
                    if (out_ready) begin
                        void'(qa.pop_front());
                        xfer_a++;
                    end
                end
            end
            if (ov_a && !pv_a) begin
                rise_a  = cyc - load_start;
                first_a = xo_a;
                chk("a_iter_cnt", it_a, exp_it_a);
                chk("a_timeout", to_a, exp_to_a);
            end
            pv_a = ov_a;
            if (ov_t) begin
                if (qt.size() == 0) chk("t_extra_out", 64'(qt.size()), 64'd1);
                else begin
                    chk("t_x_out", xo_t, qt[0].x);
                    chk("t_x_last", xl_t, qt[0].last);
                    if (out_ready) begin
                        void'(qt.pop_front());
                        xfer_t++;
                    end
                end
            end
            if (ov_t && !pv_t) begin
                rise_t = cyc - load_start;
                chk("t_iter_cnt", it_t, exp_it_t);
                chk("t_timeout", to_t, exp_to_t);
            end
            pv_t = ov_t;
        end
    end

    // Reference Gauss-Seidel with zero-padded neighbours; result left in mx.
    task automatic model(input longint tv, input int maxit, output int its, output bit to);
        longint xp[N+6];
        longint s, xn, dd, md;
        for (int i = 0; i < N + 6; i++) xp[i] = 0;
        its = 0;
        to  = 1'b0;
        while (1) begin
            md = 0;
            for (int r = 0; r < N; r++) begin
                s = (bvec[r] <<< FRAC) + 13 * (xp[r+2] + xp[r+4])
                  - 6 * (xp[r+1] + xp[r+5]) + xp[r] + xp[r+6];
                xn = (s * 3277) >>> 16;
                if (xn > 64'sd2147483647) xn = 64'sd2147483647;
                if (xn < -64'sd2147483648) xn = -64'sd2147483648;
                dd = xn - xp[r+3];
                if (dd < 0) dd = -dd;
                if (dd > md) md = dd;
                xp[r+3] = xn;
            end
            its++;
            if (md <= tv) break;
            if (its == maxit) begin
                to = 1'b1;
                break;
            end
        end
        for (int i = 0; i < N; i++) mx[i] = xp[i+3];
    endtask

    task automatic prep(input logic [X_W-1:0] tv);
        exp_t e;
        model(longint'(tv), 255, exp_it_a, exp_to_a);
        for (int i = 0; i < N; i++) begin
            e.x = mx[i][X_W-1:0];
            e.last = (i == N - 1);
            qa.push_back(e);
        end
        model(longint'(tv), 4, exp_it_t, exp_to_t);
        for (int i = 0; i < N; i++) begin
            e.x = mx[i][X_W-1:0];
            e.last = (i == N - 1);
            qt.push_back(e);
        end
    endtask

    // tol is scrambled after b_0 to show it is latched with the first sample.
    task automatic load_seq(input logic [X_W-1:0] tv, input int gap_after, input int gap_len);
        xfer_a = 0;
        xfer_t = 0;
        rise_a = -1;
        rise_t = -1;
        out_ready = 1'b1;
        chk("busy_before_load", busy_a, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i == gap_after)
                for (int g = 0; g < gap_len; g++) begin
                    in_en = 1'b0;
                    b_in  = B_W'($urandom);
                    tick;
                end
            in_en = 1'b1;
            b_in  = bvec[i][B_W-1:0];
            if (i == 0) begin
                tol = tv;
                load_start = cyc;
            end
            tick;
            if (i == 0) begin
                tol = ~tv;
                chk("busy_in_load", busy_a, 1'b1);
            end
        end
        in_en = 1'b0;
    endtask

    task automatic finish_solve(input logic [X_W-1:0] tv, input int extra, input int junk, input bit bp);
        int stall;
        bit ok;
        prep(tv);
        for (int c = 0; c < junk; c++) begin
            in_en = 1'b1;
            b_in  = B_W'($urandom);
            tick;
        end
        in_en = 1'b0;
        stall = 0;
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (bp && xfer_a == 3 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else if (bp && stall >= 5) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            tick;
            if (!busy_a && !busy_t && qa.size() == 0 && qt.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        n_cmp++;
        assert (ok) else begin
            n_bad++;
            $error("FAIL done_budget: observed no completion expected completion within 8000 cycles");
        end
        chk("a_transfers", xfer_a, N);
        chk("t_transfers", xfer_t, N);
        chk("a_rise_cycle", rise_a, N + extra + exp_it_a * N);
        chk("t_rise_cycle", rise_t, N + extra + exp_it_t * N);
        chk("a_iter_hold", it_a, exp_it_a);
        chk("t_timeout_hold", to_t, exp_to_t);
        chk("a_valid_after", ov_a, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy_a"}, busy_a, 1'b0);
        chk({tag, "_valid_a"}, ov_a, 1'b0);
        chk({tag, "_x_a"}, xo_a, '0);
        chk({tag, "_last_a"}, xl_a, 1'b0);
        chk({tag, "_iter_a"}, it_a, '0);
        chk({tag, "_to_a"}, to_a, 1'b0);
        chk({tag, "_busy_t"}, busy_t, 1'b0);
        chk({tag, "_valid_t"}, ov_t, 1'b0);
        chk({tag, "_x_t"}, xo_t, '0);
        chk({tag, "_iter_t"}, it_t, '0);
        chk({tag, "_to_t"}, to_t, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_en = 1'b0;
        b_in = '0;
        tol = '0;
        out_ready = 1'b0;
        tick;
        tick;
        chk_zero("reset");
        reset_n = 1'b1;
        tick;

        // All-zero b, tol 0: a single sweep, out_valid in cycle 32.
        for (int i = 0; i < N; i++) bvec[i] = 0;
        load_seq(32'h0, N, 0);
        finish_solve(32'h0, 0, 0, 1'b0);
        chk("zero_rise_32", rise_a, 32);

        // Impulse with loose tolerance: x[0] = 20*3277.
        bvec[0] = 20;
        load_seq(32'hFFFF_FFFF, N, 0);
        finish_solve(32'hFFFF_FFFF, 0, 0, 1'b0);
        chk("impulse_first_x", first_a, 32'd65540);

        // Ramp b, tol 0 (timeout on the MAX_ITER=4 instance), then tol 16.
        for (int i = 0; i < N; i++) bvec[i] = i * 100;
        load_seq(32'h0, N, 0);
        finish_solve(32'h0, 0, 0, 1'b0);
        load_seq(32'd16, N, 0);
        finish_solve(32'd16, 0, 0, 1'b0);
        chk("ramp_a_converged", to_a, 1'b0);

        // Backpressure: 5-cycle stall at j=3, then random ready.
        for (int i = 0; i < N; i++) bvec[i] = i * 37 - 200;
        load_seq(32'hFFFF_FFFF, N, 0);
        finish_solve(32'hFFFF_FFFF, 0, 0, 1'b1);

        // Load gap of 3 cycles and in_en activity during ITER.
        for (int i = 0; i < N; i++) bvec[i] = 300 - i * 45;
        load_seq(32'd5000, 6, 3);
        finish_solve(32'd5000, 3, 8, 1'b0);

        // Reset pulse in the middle of ITER.
        for (int i = 0; i < N; i++) bvec[i] = i * 100;
        load_seq(32'h0, N, 0);
        for (int c = 0; c < 20; c++) begin
            in_en = 1'b1;
            b_in = B_W'($urandom);
            tick;
        end
        in_en = 1'b0;
        reset_n = 1'b0;
        #1;
        qa.delete();
        qt.delete();
        chk_zero("rst_async");
        tick;
        chk_zero("rst_next");
        reset_n = 1'b1;
        tick;

        // Fresh load after reset reproduces the impulse result.
        for (int i = 0; i < N; i++) bvec[i] = 0;
        bvec[0] = 20;
        load_seq(32'hFFFF_FFFF, N, 0);
        finish_solve(32'hFFFF_FFFF, 0, 0, 1'b0);
        chk("post_reset_first_x", first_a, 32'd65540);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
